// File: rtl/sng_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sng_pkg                                                         |
// | Purpose  : Shared types and helpers for the stochastic number generator    |
// |            bank: frame FSM state encoding, default operand width and the   |
// |            channel slice index used to split packed operand/tap vectors.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sng_pkg;

    localparam int W_DEF = 8;

    // Frame FSM encoding: fixed width so external tooling can decode the state.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN
    } sng_state_e;

    // LSB position of channel `ch` inside a packed vector of `w`-bit lanes.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sng_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sng_bank_if                                                     |
// | Purpose  : Operand load channel of the SNG bank (valid/ready handshake     |
// |            carrying one packed vector of NCH W-bit operands).              |
// | Signals  : LOAD_VALID - producer has an operand vector on VAL              |
// |            LOAD_READY - bank shadow register can take a vector             |
// |            VAL        - NCH*W operands, channel i = VAL[i*W +: W]          |
// | Modports : master (operand producer), slave (sng_bank)                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sng_bank_if
    import sng_pkg::*;
#(
    parameter int NCH = 16,
    parameter int W   = W_DEF
);
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic [NCH*W-1:0] VAL;

    modport master (
        output LOAD_VALID,
        output VAL,
        input  LOAD_READY
    );

    modport slave (
        input  LOAD_VALID,
        input  VAL,
        output LOAD_READY
    );
endinterface
`default_nettype wire

// File: rtl/sng_cmp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sng_cmp                                                         |
// | Purpose  : One channel of the SNG bank: registered unsigned compare of the |
// |            random tap against the active operand. Output is forced to 0    |
// |            whenever the channel is not enabled.                            |
// | Ports    : clk, rst (sync, active-high), i_en, i_op, i_rnd -> o_bit        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sng_cmp
    import sng_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          i_en,
    input  wire  [W-1:0] i_op,
    input  wire  [W-1:0] i_rnd,
    output logic         o_bit
);
    logic bit_d;
    logic bit_q;

    // P(bit=1) = op / 2^W for a uniformly distributed tap.
    always_comb begin
        bit_d = i_en && (i_rnd < i_op);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign o_bit = bit_q;
endmodule
`default_nettype wire

// File: rtl/sng_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sng_bank                                                        |
// | Purpose  : Bank of NCH stochastic number generators. Operands arrive via a |
// |            double buffer (shadow -> active) so frames of FRAME_LEN bits    |
// |            run back-to-back; each bit is RND_i < active_i.                 |
// | Ports    : TRIG (clock), RESET (sync, active-high), ld (operand load,      |
// |            slave modport), RND (LFSR taps), STREAM, STREAM_VALID,          |
// |            FRAME_LAST, LFSR_RESEED (frame-start pulse), BUSY (in RUN)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sng_bank
    import sng_pkg::*;
#(
    parameter int NCH       = 16,
    parameter int W         = W_DEF,
    parameter int FRAME_LEN = 256,
    parameter bit RESEED_EN = 1'b0
) (
    input  wire               TRIG,
    input  wire               RESET,
    sng_bank_if.slave         ld,
    input  wire   [NCH*W-1:0] RND,
    output logic  [NCH-1:0]   STREAM,
    output logic              STREAM_VALID,
    output logic              FRAME_LAST,
    output logic              LFSR_RESEED,
    output logic              BUSY
);
    localparam int            CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    sng_state_e       state_q, state_d;
    logic [NCH*W-1:0] shadow_q, shadow_d;
    logic [NCH*W-1:0] active_q, active_d;
    logic             shadow_full_q, shadow_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stream_valid_q, stream_valid_d;
    logic             frame_last_q, frame_last_d;
    logic             reseed_q, reseed_d;

    logic             w_ready;
    logic             w_accept;
    logic             w_cnt_last;
    logic             w_run;
    logic             w_swap;

    // RESET gates ready so a load offered during reset is never taken.
    assign w_ready    = !shadow_full_q && !RESET;
    assign w_accept   = ld.LOAD_VALID && w_ready;
    assign w_cnt_last = (cnt_q == CNT_LAST);
    assign w_run      = (state_q == RUN);

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        shadow_full_d  = shadow_full_q;
        cnt_d          = cnt_q;
        stream_valid_d = 1'b0;
        frame_last_d   = 1'b0;
        reseed_d       = 1'b0;
        w_swap         = 1'b0;

        case (state_q)
            IDLE: begin
                if (shadow_full_q) begin
                    w_swap  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                stream_valid_d = 1'b1;
                frame_last_d   = w_cnt_last;
                cnt_d          = cnt_q + CW'(1);
                if (w_cnt_last) begin
                    // Swap on the last bit gives a gapless next frame; a load
                    // accepted on this same edge is not yet visible here.
                    if (shadow_full_q) begin
                        w_swap = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_swap) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            cnt_d         = '0;
            reseed_d      = RESEED_EN;
        end

        // Never coincides with a swap: a swap needs shadow_full, accept needs it clear.
        if (w_accept) begin
            shadow_d      = ld.VAL;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge TRIG) begin
        if (RESET) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            active_q       <= '0;
            shadow_full_q  <= 1'b0;
            cnt_q          <= '0;
            stream_valid_q <= 1'b0;
            frame_last_q   <= 1'b0;
            reseed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            shadow_full_q  <= shadow_full_d;
            cnt_q          <= cnt_d;
            stream_valid_q <= stream_valid_d;
            frame_last_q   <= frame_last_d;
            reseed_q       <= reseed_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int LSB = int'(ch_lsb(i, W));
        sng_cmp #(.W(W)) u_cmp (
            .clk   (TRIG),
            .rst   (RESET),
            .i_en  (w_run),
            .i_op  (active_q[LSB +: W]),
            .i_rnd (RND[LSB +: W]),
            .o_bit (STREAM[i])
        );
    end

    assign ld.LOAD_READY = w_ready;
    assign STREAM_VALID  = stream_valid_q;
    assign FRAME_LAST    = frame_last_q;
    assign LFSR_RESEED   = reseed_q;
    assign BUSY          = w_run;
endmodule
`default_nettype wire

// File: tb/tb_sng_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sng_bank                                                     |
// | Purpose  : Directed self-checking bench for sng_bank. u_dut runs 256-bit   |
// |            frames on a ramp RND; u_dut2 runs 4-bit frames with reseed on,  |
// |            fed by a bench LFSR16 model seeded with 16'hACE1.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sng_bank;
    localparam int          NCH  = 16;
    localparam int          W    = 8;
    localparam int          FL   = 256;
    localparam int          FL2  = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [NCH*W-1:0] rnd;
    logic [NCH-1:0]   stream;
    logic             stream_valid, frame_last, lfsr_reseed, busy;
    sng_bank_if #(.NCH(NCH), .W(W)) ld_if ();

    sng_bank #(.NCH(NCH), .W(W), .FRAME_LEN(FL), .RESEED_EN(1'b0)) u_dut (
        .TRIG         (clk),
        .RESET        (rst),
        .ld           (ld_if),
        .RND          (rnd),
        .STREAM       (stream),
        .STREAM_VALID (stream_valid),
        .FRAME_LAST   (frame_last),
        .LFSR_RESEED  (lfsr_reseed),
        .BUSY         (busy)
    );

    // ---------------- reseed DUT + LFSR model ----------------
    logic [NCH*W-1:0] rnd2;
    logic [NCH-1:0]   stream2;
    logic             stream_valid2, frame_last2, lfsr_reseed2, busy2;
    logic [15:0]      lfsr_q = 16'h0001;
    sng_bank_if #(.NCH(NCH), .W(W)) ld2_if ();

    sng_bank #(.NCH(NCH), .W(W), .FRAME_LEN(FL2), .RESEED_EN(1'b1)) u_dut2 (
        .TRIG         (clk),
        .RESET        (rst),
        .ld           (ld2_if),
        .RND          (rnd2),
        .STREAM       (stream2),
        .STREAM_VALID (stream_valid2),
        .FRAME_LAST   (frame_last2),
        .LFSR_RESEED  (lfsr_reseed2),
        .BUSY         (busy2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Tap i is the state rotated right by i, low byte.
    function automatic logic [NCH*W-1:0] taps(input logic [15:0] s);
        logic [NCH*W-1:0] t;
        logic [31:0]      d;
        for (int i = 0; i < NCH; i++) begin
            d = {s, s} >> i;
            t[i*W +: W] = d[7:0];
        end
        return t;
    endfunction

    // The seed load presents SEED taps in the same cycle the reseed pulse is high.
    always @(posedge clk) lfsr_q <= lfsr_step(lfsr_reseed2 ? SEED : lfsr_q);
    assign rnd2 = taps(lfsr_reseed2 ? SEED : lfsr_q);

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*W-1:0] ramp(input int k);
        logic [NCH*W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(k);
        return r;
    endfunction

    function automatic logic [NCH*W-1:0] mkval(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d);
        logic [NCH*W-1:0] v;
        v = '0;
        v[7:0]   = a;
        v[15:8]  = b;
        v[23:16] = c;
        v[31:24] = d;
        return v;
    endfunction

    logic [NCH*W-1:0] val2;

    function automatic logic [NCH-1:0] exp2(input int k);
        logic [15:0]      s;
        logic [NCH*W-1:0] t;
        logic [NCH-1:0]   e;
        s = SEED;
        for (int j = 0; j < k; j++) s = lfsr_step(s);
        t = taps(s);
        for (int i = 0; i < NCH; i++) e[i] = (t[i*W +: W] < val2[i*W +: W]);
        return e;
    endfunction

    // Per-run statistics for the main DUT.
    int ones [2][4];
    int nvalid, nlast, hi_ones;
    int last_pos [4];

    task automatic clear_stats();
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 4; c++) ones[f][c] = 0;
        for (int j = 0; j < 4; j++) last_pos[j] = -1;
        nvalid  = 0;
        nlast   = 0;
        hi_ones = 0;
    endtask

    task automatic collect(input int k);
        int f;
        f = (k / FL > 1) ? 1 : k / FL;
        if (stream_valid) nvalid++;
        for (int c = 0; c < 4; c++) ones[f][c] += int'(stream[c]);
        hi_ones += $countones(stream[NCH-1:4]);
        if (frame_last) begin
            if (nlast < 4) last_pos[nlast] = k;
            nlast++;
        end
    endtask

    // Present one vector; returns right after the accept edge with VAL scrambled.
    task automatic load_main(input logic [NCH*W-1:0] v);
        ld_if.VAL        = v;
        ld_if.LOAD_VALID = 1'b1;
        tick();
        ld_if.LOAD_VALID = 1'b0;
        ld_if.VAL        = '1;
    endtask

    int cnt_a, cnt_b, cnt_c;
    int rdy_bad;
    logic rdy_at_swap;

    initial begin
        ld_if.LOAD_VALID  = 1'b0;
        ld_if.VAL         = '0;
        ld2_if.LOAD_VALID = 1'b0;
        ld2_if.VAL        = '0;
        rnd               = '0;

        // ---- reset state ----
        rst = 1'b1;
        ld_if.LOAD_VALID = 1'b1;
        ld_if.VAL        = mkval(8'd99, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        check_eq("rst_outputs", {stream, stream_valid, frame_last, lfsr_reseed, busy}, '0);
        check_eq("rst_ready_low", ld_if.LOAD_READY, 1'b0);
        check_eq("rst_dut2_reseed", {lfsr_reseed2, busy2, stream_valid2}, '0);
        ld_if.LOAD_VALID = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_ready_high", ld_if.LOAD_READY, 1'b1);

        // ---- idle: 1000 cycles, no loads (load during reset must be dropped) ----
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cnt_a += int'(stream_valid) + int'(busy) + int'(stream_valid2) + int'(busy2);
            cnt_b += int'(lfsr_reseed) + int'(lfsr_reseed2);
        end
        check_eq("idle_valid_busy", cnt_a, 0);
        check_eq("idle_reseed", cnt_b, 0);

        // ---- ones count: 0, 1, 128, 255 on a shared ramp ----
        load_main(mkval(8'd0, 8'd1, 8'd128, 8'd255));
        check_eq("t1_ready_after_accept", ld_if.LOAD_READY, 1'b0);
        tick();
        check_eq("t1_busy_after_xfer", busy, 1'b1);
        check_eq("t1_valid_before_bit0", stream_valid, 1'b0);
        clear_stats();
        for (int k = 0; k < FL; k++) begin
            rnd = ramp(k);
            tick();
            collect(k);
        end
        check_eq("t1_ones_v0", ones[0][0], 0);
        check_eq("t1_ones_v1", ones[0][1], 1);
        check_eq("t1_ones_v128", ones[0][2], 128);
        check_eq("t1_ones_v255", ones[0][3], 255);
        check_eq("t1_ones_unused", hi_ones, 0);
        check_eq("t1_valid_count", nvalid, FL);
        check_eq("t1_last_count", nlast, 1);
        check_eq("t1_last_pos", last_pos[0], FL - 1);
        tick();
        check_eq("t1_after_frame", {stream_valid, busy, stream}, '0);

        // ---- back-to-back frames: 64 then 192 on channel 0 ----
        load_main(mkval(8'd64, 8'd0, 8'd0, 8'd0));
        tick();
        clear_stats();
        rdy_bad     = 0;
        rdy_at_swap = 1'b0;
        for (int k = 0; k < 2 * FL; k++) begin
            rnd = ramp(k % FL);
            if (k == 10) begin
                ld_if.VAL        = mkval(8'd192, 8'd0, 8'd0, 8'd0);
                ld_if.LOAD_VALID = 1'b1;
            end
            tick();
            if (k == 10) begin
                ld_if.LOAD_VALID = 1'b0;
                ld_if.VAL        = '1;
            end
            collect(k);
            if (k >= 10 && k < FL - 1) rdy_bad += int'(ld_if.LOAD_READY);
            if (k == FL - 1) rdy_at_swap = ld_if.LOAD_READY;
        end
        check_eq("t2_ready_low_while_full", rdy_bad, 0);
        check_eq("t2_ready_after_swap", rdy_at_swap, 1'b1);
        check_eq("t2_f1_ones", ones[0][0], 64);
        check_eq("t2_f2_ones", ones[1][0], 192);
        check_eq("t2_valid_no_gap", nvalid, 2 * FL);
        check_eq("t2_last_count", nlast, 2);
        check_eq("t2_last_pos0", last_pos[0], FL - 1);
        check_eq("t2_last_pos1", last_pos[1], 2 * FL - 1);
        tick();
        check_eq("t2_idle_after", {stream_valid, busy}, 2'b00);

        // ---- late load on the final cycle: one bubble ----
        load_main(mkval(8'd64, 8'd0, 8'd0, 8'd0));
        tick();
        clear_stats();
        for (int k = 0; k < FL; k++) begin
            rnd = ramp(k);
            if (k == FL - 1) begin
                ld_if.VAL        = mkval(8'd32, 8'd0, 8'd0, 8'd0);
                ld_if.LOAD_VALID = 1'b1;
            end
            tick();
            ld_if.LOAD_VALID = 1'b0;
            ld_if.VAL        = '1;
            collect(k);
        end
        check_eq("t3_busy_at_last", {frame_last, busy}, 2'b10);
        tick();
        check_eq("t3_bubble", {stream_valid, busy}, 2'b01);
        for (int k = FL; k < 2 * FL; k++) begin
            rnd = ramp(k % FL);
            tick();
            collect(k);
        end
        check_eq("t3_f1_ones", ones[0][0], 64);
        check_eq("t3_f2_ones", ones[1][0], 32);
        check_eq("t3_valid_count", nvalid, 2 * FL);
        check_eq("t3_last_pos1", last_pos[1], 2 * FL - 1);
        tick();

        // ---- reset mid-frame with shadow full ----
        load_main(mkval(8'd128, 8'd0, 8'd0, 8'd0));
        tick();
        clear_stats();
        for (int k = 0; k < 100; k++) begin
            rnd = ramp(k);
            if (k == 5) begin
                ld_if.VAL        = mkval(8'd200, 8'd0, 8'd0, 8'd0);
                ld_if.LOAD_VALID = 1'b1;
            end
            tick();
            ld_if.LOAD_VALID = 1'b0;
            ld_if.VAL        = '1;
            collect(k);
        end
        check_eq("t4_ones_before_rst", ones[0][0], 100);
        rnd              = ramp(100);
        rst              = 1'b1;
        ld_if.VAL        = mkval(8'd50, 8'd0, 8'd0, 8'd0);
        ld_if.LOAD_VALID = 1'b1;
        tick();
        check_eq("t4_outputs_on_rst", {stream, stream_valid, frame_last, lfsr_reseed, busy}, '0);
        check_eq("t4_ready_in_rst", ld_if.LOAD_READY, 1'b0);
        rst              = 1'b0;
        ld_if.LOAD_VALID = 1'b0;
        #1;
        check_eq("t4_ready_after_rst", ld_if.LOAD_READY, 1'b1);
        cnt_a = 0;
        cnt_c = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cnt_a += int'(stream_valid) + int'(busy);
            cnt_c += int'(frame_last);
        end
        check_eq("t4_no_restart", cnt_a, 0);
        check_eq("t4_no_last", cnt_c, 0);

        // ---- reseed: two back-to-back frames from SEED must repeat ----
        for (int i = 0; i < NCH; i++) val2[i*W +: W] = W'(16 * i + 8);
        cnt_b = 0;
        ld2_if.VAL        = val2;
        ld2_if.LOAD_VALID = 1'b1;
        tick();                                      // accept
        cnt_b += int'(lfsr_reseed2);
        tick();                                      // transfer
        cnt_b += int'(lfsr_reseed2);
        check_eq("t6_reseed_start", {lfsr_reseed2, busy2}, 2'b11);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL2; k++) begin
                tick();                              // f=0,k=0 edge also re-accepts val2
                ld2_if.LOAD_VALID = 1'b0;
                cnt_b += int'(lfsr_reseed2);
                check_eq($sformatf("t6_f%0d_bit%0d", f, k), {stream_valid2, stream2},
                         {1'b1, exp2(k)});
            end
            check_eq($sformatf("t6_f%0d_last", f), frame_last2, 1'b1);
        end
        tick();
        cnt_b += int'(lfsr_reseed2);
        check_eq("t6_idle_after", {stream_valid2, busy2}, 2'b00);
        check_eq("t6_reseed_pulses", cnt_b, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
